// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: opcode constants,
// forwarding-mux encodings and the per-stage destination tag.
package fwd_hazard_unit_pkg;

   localparam logic [3:0] OP_ALU     = 4'b0000;
   localparam logic [3:0] OP_LOAD    = 4'b1000;
   localparam logic [3:0] OP_STORE   = 4'b1011;
   localparam logic [3:0] OP_BR_EQ   = 4'b0100;
   localparam logic [3:0] OP_BR_NE   = 4'b0101;
   localparam logic [3:0] OP_BR_LT   = 4'b0110;
   localparam logic [3:0] FUNCT_MULT = 4'b0001;
   localparam logic [3:0] FUNCT_DIV  = 4'b0010;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   // Tags store register numbers at a fixed width so one struct serves any REG_AW up to 8.
   localparam int TAG_AW = 8;

   typedef struct packed {
      logic              valid;
      logic              wr_en;
      logic [TAG_AW-1:0] wd;
      logic              wr_r0;
      logic              is_load;
   } stage_tag_t;

   localparam stage_tag_t TAG_NONE = '0;

   function automatic logic prim_hit(stage_tag_t t, logic [TAG_AW-1:0] a);
      return t.valid & t.wr_en & (t.wd == a);
   endfunction

   function automatic logic sec_hit(stage_tag_t t, logic [TAG_AW-1:0] a);
      return t.valid & t.wr_r0 & (a == '0);
   endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// One read port's forwarding mux: youngest matching stage wins, and inside a
// stage the secondary (r0) result beats the primary one.
module fwd_port_sel
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] addr,
   input  logic              used,
   input  stage_tag_t        ex_tag,
   input  stage_tag_t        mem_tag,
   input  stage_tag_t        wb_tag,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] ex_res,
   input  logic [DATA_W-1:0] ex_res2,
   input  logic [DATA_W-1:0] mem_res,
   input  logic [DATA_W-1:0] mem_res2,
   input  logic [DATA_W-1:0] wb_res,
   input  logic [DATA_W-1:0] wb_res2,
   output logic [1:0]        sel,
   output logic [DATA_W-1:0] data,
   output logic              ex_prim_hit
);

   logic [TAG_AW-1:0] addr_w;

   assign addr_w = TAG_AW'(addr);

   always_comb begin
      sel         = FWD_RF;
      data        = rf_data;
      ex_prim_hit = used & prim_hit(ex_tag, addr_w);
      if (used) begin
         if (sec_hit(ex_tag, addr_w)) begin
            sel  = FWD_EX;
            data = ex_res2;
         end else if (prim_hit(ex_tag, addr_w)) begin
            sel  = FWD_EX;
            data = ex_res;
         end else if (sec_hit(mem_tag, addr_w)) begin
            sel  = FWD_MEM;
            data = mem_res2;
         end else if (prim_hit(mem_tag, addr_w)) begin
            sel  = FWD_MEM;
            data = mem_res;
         end else if (sec_hit(wb_tag, addr_w)) begin
            sel  = FWD_WB;
            data = wb_res2;
         end else if (prim_hit(wb_tag, addr_w)) begin
            sel  = FWD_WB;
            data = wb_res;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for the 5-stage pipeline: tracks EX/MEM/WB
// destination tags and produces operand muxing, load-use bubbles and mult/div stalls.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 4,
   parameter int NUM_RD     = 3,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic [NUM_RD*REG_AW-1:0] dec_rd_addr,
   input  logic [NUM_RD-1:0]        dec_rd_used,
   input  logic                     dec_wr_en,
   input  logic [REG_AW-1:0]        dec_wd,
   input  logic                     dec_wr_r0,
   input  logic                     dec_is_load,
   input  logic                     dec_is_muldiv,
   input  logic                     flush,
   input  logic [NUM_RD*DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0]        ex_res,
   input  logic [DATA_W-1:0]        mem_res,
   input  logic [DATA_W-1:0]        wb_res,
   input  logic [DATA_W-1:0]        ex_res2,
   input  logic [DATA_W-1:0]        mem_res2,
   input  logic [DATA_W-1:0]        wb_res2,
   output logic [NUM_RD*DATA_W-1:0] fwd_data,
   output logic [NUM_RD*2-1:0]      fwd_sel,
   output logic                     stall,
   output logic                     bubble,
   output logic                     mdu_busy,
   output logic [CNT_W-1:0]         stall_cnt
);

   localparam int MC_W = $clog2(MULDIV_LAT + 1);

   stage_tag_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag;
   logic [MC_W-1:0]   mdu_cnt_q, mdu_cnt_d;
   logic              kill_q, kill_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [NUM_RD-1:0] ex_prim_hit;
   logic              busy, load_use, kill_now;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      fwd_port_sel #(
         .DATA_W(DATA_W),
         .REG_AW(REG_AW)
      ) u_sel (
         .addr       (dec_rd_addr[p*REG_AW +: REG_AW]),
         .used       (dec_rd_used[p]),
         .ex_tag     (ex_q),
         .mem_tag    (mem_q),
         .wb_tag     (wb_q),
         .rf_data    (rf_data[p*DATA_W +: DATA_W]),
         .ex_res     (ex_res),
         .ex_res2    (ex_res2),
         .mem_res    (mem_res),
         .mem_res2   (mem_res2),
         .wb_res     (wb_res),
         .wb_res2    (wb_res2),
         .sel        (fwd_sel[p*2 +: 2]),
         .data       (fwd_data[p*DATA_W +: DATA_W]),
         .ex_prim_hit(ex_prim_hit[p])
      );
   end

   always_comb begin
      busy     = (mdu_cnt_q != '0);
      kill_now = flush | kill_q;
      load_use = ex_q.is_load & (|ex_prim_hit);
      // A killed ID instruction has no operands worth waiting for, so it never load-use stalls.
      stall    = busy | (load_use & ~kill_now);
      bubble   = ~busy & (load_use | kill_now);

      id_tag         = TAG_NONE;
      id_tag.valid   = dec_valid;
      id_tag.wr_en   = dec_wr_en;
      id_tag.wd      = TAG_AW'(dec_wd);
      id_tag.wr_r0   = dec_wr_r0;
      id_tag.is_load = dec_is_load;

      ex_d      = ex_q;
      mem_d     = ex_q;
      wb_d      = mem_q;
      mdu_cnt_d = mdu_cnt_q;
      kill_d    = kill_q;

      if (busy) begin
         mem_d     = TAG_NONE;
         mdu_cnt_d = mdu_cnt_q - MC_W'(1);
         kill_d    = kill_q | flush;
      end else begin
         ex_d   = (bubble || !dec_valid) ? TAG_NONE : id_tag;
         kill_d = 1'b0;
         if (ex_d.valid && dec_is_muldiv) begin
            mdu_cnt_d = MC_W'(MULDIV_LAT - 1);
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= TAG_NONE;
         mem_q       <= TAG_NONE;
         wb_q        <= TAG_NONE;
         mdu_cnt_q   <= '0;
         kill_q      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         mdu_cnt_q   <= mdu_cnt_d;
         kill_q      <= kill_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mdu_busy  = busy;
   assign stall_cnt = stall_cnt_q;

endmodule
